clock_enable_sequencer: RTL and testbench

Runtime-configurable clock-enable controller. Holds a programmable division ratio and a pulse count, then, on command, emits a burst of single-cycle enable strobes or a continuous strobe train. It sits between the control/register logic and the enable-driven datapath. It replaces fixed-ratio enables wherever software must start, stop or re-time the enable.

---
 rtl/clock_enable_sequencer.sv | 155 +++++++++++++++
 tb/tb_clock_enable_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_sequencer.sv
// ============================================================================
//  Module      : clock_enable_sequencer
//  Description : Runtime-configurable clock-enable controller. Holds a
//                divider ratio R and a pulse count, and on a start command
//                emits either a finite burst of single-cycle enable strobes
//                (one every R+1 cycles) or a continuous strobe train.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    cfg_valid    in   configuration offer
//    cfg_ready    out  high in IDLE; cfg accepted when high with cfg_valid
//    cfg_ratio    in   [CNT_W]   divider ratio R (period R+1 cycles)
//    cfg_count    in   [BURST_W] strobes per burst, 0 = continuous
//    start        in   begin sequence (sampled in IDLE only)
//    stop         in   abort sequence (honoured in RUN only)
//    o_en         out  registered one-cycle enable strobe
//    busy         out  high while in RUN
//    done         out  one-cycle flag coincident with final burst strobe
//    pulses_left  out  [BURST_W] strobes remaining (0 in continuous mode)
// ============================================================================
`default_nettype none

module clock_enable_sequencer #(
  parameter int CNT_W         = 8,
  parameter int BURST_W       = 16,
  parameter int DEFAULT_RATIO = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_ratio,
  input  logic [BURST_W-1:0] cfg_count,
  input  logic               start,
  input  logic               stop,
  output logic               o_en,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulses_left
);

  localparam logic [CNT_W-1:0] C_DEFAULT_RATIO = CNT_W'(DEFAULT_RATIO);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [CNT_W-1:0]   ratio_q,     ratio_d;
  logic [BURST_W-1:0] count_q,     count_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic               en_q,        en_d;

  logic               cfg_accept;
  logic [BURST_W-1:0] eff_count;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ratio_q     <= C_DEFAULT_RATIO;
      count_q     <= '0;
      remaining_q <= '0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      en_q        <= en_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    en_d        = 1'b0;

    cfg_accept  = cfg_valid && (state_q == ST_IDLE);
    // A config accepted on the same edge as start takes effect immediately.
    eff_count   = cfg_accept ? cfg_count : count_q;

    if (cfg_accept) begin
      ratio_d = cfg_ratio;
      count_d = cfg_count;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          remaining_d = eff_count;
        end
      end

      ST_RUN: begin
        // stop pre-empts any strobe due on this edge
        if (stop) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          remaining_d = '0;
        end else if (cnt_q == ratio_q) begin
          en_d  = 1'b1;
          cnt_d = '0;
          if (count_q != '0) begin
            if (remaining_q == BURST_W'(1)) begin
              state_d     = ST_DONE;
              remaining_d = '0;
            end else begin
              remaining_d = remaining_q - BURST_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cfg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign o_en        = en_q;
  assign pulses_left = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_enable_sequencer.sv
// ============================================================================
//  Module      : tb_clock_enable_sequencer
//  Description : Directed self-checking bench for clock_enable_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_enable_sequencer;

  localparam int CNT_W   = 8;
  localparam int BURST_W = 16;

  logic               clk;
  logic               rst_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_ratio;
  logic [BURST_W-1:0] cfg_count;
  logic               start;
  logic               stop;
  logic               o_en;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] pulses_left;

  int n_total;
  int n_pass;

  clock_enable_sequencer #(
    .CNT_W         (CNT_W),
    .BURST_W       (BURST_W),
    .DEFAULT_RATIO (50)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ratio   (cfg_ratio),
    .cfg_count   (cfg_count),
    .start       (start),
    .stop        (stop),
    .o_en        (o_en),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // advance one rising edge, then settle 1 time unit before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_cfg(input logic [CNT_W-1:0] r, input logic [BURST_W-1:0] c);
    cfg_valid = 1'b1;
    cfg_ratio = r;
    cfg_count = c;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ratio = '0;
    cfg_count = '0;
    start     = 1'b0;
    stop      = 1'b0;

    // ---------------- reset state ----------------
    #3;
    check("rst_o_en",      32'(o_en),        32'd0);
    check("rst_busy",      32'(busy),        32'd0);
    check("rst_done",      32'(done),        32'd0);
    check("rst_cfg_ready", 32'(cfg_ready),   32'd1);
    check("rst_pulses",    32'(pulses_left), 32'd0);
    apply_reset();

    // ---------------- S1: R=3 count=4 ----------------
    send_cfg(8'd3, 16'd4);
    pulse_start();
    check("s1_busy0",   32'(busy),        32'd1);
    check("s1_pulses0", 32'(pulses_left), 32'd4);
    check("s1_en0",     32'(o_en),        32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("s1_en",     32'(o_en),        32'((k % 4) == 0));
      check("s1_pulses", 32'(pulses_left), 32'(4 - k / 4));
      check("s1_done",   32'(done),        32'(k == 16));
      check("s1_busy",   32'(busy),        32'(k < 16));
    end
    tick();
    check("s1_end_busy",  32'(busy),      32'd0);
    check("s1_end_ready", 32'(cfg_ready), 32'd1);
    check("s1_end_en",    32'(o_en),      32'd0);
    check("s1_end_done",  32'(done),      32'd0);

    // ---------------- S2: defaults, continuous ----------------
    apply_reset();
    pulse_start();
    for (int k = 1; k <= 110; k++) begin
      tick();
      check("s2_en",     32'(o_en),        32'((k % 51) == 0));
      check("s2_done",   32'(done),        32'd0);
      check("s2_pulses", 32'(pulses_left), 32'd0);
      check("s2_busy",   32'(busy),        32'd1);
    end
    pulse_stop();
    check("s2_stop_busy",  32'(busy),      32'd0);
    check("s2_stop_ready", 32'(cfg_ready), 32'd1);
    check("s2_stop_en",    32'(o_en),      32'd0);
    for (int k = 0; k < 60; k++) begin
      tick();
      check("s2_idle_en", 32'(o_en), 32'd0);
    end

    // ---------------- S3: R=0 count=5 ----------------
    send_cfg(8'd0, 16'd5);
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("s3_en",     32'(o_en),        32'd1);
      check("s3_done",   32'(done),        32'(k == 5));
      check("s3_pulses", 32'(pulses_left), 32'(5 - k));
    end
    tick();
    check("s3_end_en",   32'(o_en), 32'd0);
    check("s3_end_busy", 32'(busy), 32'd0);

    // ---------------- S4: stop on strobe edge ----------------
    send_cfg(8'd2, 16'd10);
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("s4_en", 32'(o_en), 32'((k % 3) == 0));
    end
    check("s4_pulses_pre", 32'(pulses_left), 32'd8);
    pulse_stop();
    check("s4_en",     32'(o_en),        32'd0);
    check("s4_done",   32'(done),        32'd0);
    check("s4_pulses", 32'(pulses_left), 32'd0);
    check("s4_ready",  32'(cfg_ready),   32'd1);
    tick();
    check("s4_after_en", 32'(o_en), 32'd0);

    // ---------------- S5: cfg during RUN, bypass on start ----------------
    send_cfg(8'd1, 16'd3);
    pulse_start();
    cfg_valid = 1'b1;
    cfg_ratio = 8'd7;
    cfg_count = 16'd2;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("s5_en",    32'(o_en),      32'((k % 2) == 0));
      check("s5_ready", 32'(cfg_ready), 32'd0);
      check("s5_done",  32'(done),      32'(k == 6));
    end
    tick();
    check("s5_idle_ready", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    pulse_start();
    check("s5b_pulses0", 32'(pulses_left), 32'd2);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("s5b_en",   32'(o_en), 32'((k % 8) == 0));
      check("s5b_done", 32'(done), 32'(k == 16));
    end
    tick();
    cfg_valid = 1'b1;
    cfg_ratio = 8'd4;
    cfg_count = 16'd1;
    start     = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
    check("s5c_pulses0", 32'(pulses_left), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("s5c_en",   32'(o_en), 32'(k == 5));
      check("s5c_done", 32'(done), 32'(k == 5));
    end
    tick();

    // ---------------- S6: async reset mid-burst ----------------
    send_cfg(8'd3, 16'd4);
    pulse_start();
    for (int k = 1; k <= 4; k++) tick();
    check("s6_en_pre",   32'(o_en), 32'd1);
    check("s6_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_en",     32'(o_en),        32'd0);
    check("s6_busy",   32'(busy),        32'd0);
    check("s6_done",   32'(done),        32'd0);
    check("s6_ready",  32'(cfg_ready),   32'd1);
    check("s6_pulses", 32'(pulses_left), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    pulse_start();
    for (int k = 1; k <= 51; k++) begin
      tick();
      check("s6_en_run", 32'(o_en),        32'(k == 51));
      check("s6_pulses", 32'(pulses_left), 32'd0);
    end
    pulse_stop();
    check("s6_stop_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
